// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and instruction field constants
package core_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_IW = 16;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int FUNCT_MSB = 2;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority mux: jump over branch over increment
module pc_next_sel #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] i_pc,
  input  logic          i_jump,
  input  logic          i_pcsrc,
  input  logic [AW-1:0] i_branch_target,
  input  logic [AW-1:0] i_jump_target,
  output logic [AW-1:0] o_next_pc,
  output logic [AW-1:0] o_pcplus1
);

  logic [AW-1:0] w_pcplus1;

  // Unsigned AW-bit add; carry out is dropped so the PC wraps to zero.
  assign w_pcplus1 = i_pc + {{(AW-1){1'b0}}, 1'b1};
  assign o_pcplus1 = w_pcplus1;

  always_comb begin
    o_next_pc = w_pcplus1;
    if (i_jump) begin
      o_next_pc = i_jump_target;
    end else if (i_pcsrc) begin
      o_next_pc = i_branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, imem handshake and instruction register
module instr_fetch
  import core_pkg::*;
#(
  parameter int            AW       = DEF_AW,
  parameter int            IW       = DEF_IW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic          instr_valid,
  output logic [IW-1:0] instr,
  output logic [3:0]    op,
  output logic [2:0]    funct,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pcplus1,
  input  logic          retire,
  input  logic          pcsrc,
  input  logic          jump,
  input  logic [AW-1:0] branch_target,
  input  logic [AW-1:0] jump_target
);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic          w_ld_instr;
  logic          w_ld_pc;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_next_pc;
  logic [AW-1:0] w_pcplus1;
  logic [IW-1:0] r_instr;

  pc_next_sel #(
    .AW(AW)
  ) u_pc_next_sel (
    .i_pc            (r_pc),
    .i_jump          (jump),
    .i_pcsrc         (pcsrc),
    .i_branch_target (branch_target),
    .i_jump_target   (jump_target),
    .o_next_pc       (w_next_pc),
    .o_pcplus1       (w_pcplus1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Responses are only honoured in WAIT, so a stale rvalid seen in FETCH is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_instr  = 1'b0;
    w_ld_pc     = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        if (imem_gnt) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_ld_instr  = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          w_ld_pc     = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_ld_pc) begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
    end else if (w_ld_instr) begin
      r_instr <= imem_rdata;
    end
  end

  assign imem_req    = (r_state == FETCH);
  assign instr_valid = (r_state == HOLD);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pcplus1     = w_pcplus1;
  assign instr       = r_instr;
  assign op          = r_instr[OP_MSB:OP_LSB];
  assign funct       = r_instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit single-cycle core. Holds the PC, issues a request/grant/response handshake to instruction memory, and latches the returned word into an instruction register. Presents `op`/`funct` to the controller and `instr` to the datapath. On retire, it selects the next PC from the controller's `jump`/`pcsrc` decision.

## Interface
- `AW`, 16: PC / instruction-memory word-address width
- `IW`, 16: instruction width; `op` = `instr[15:12]`, `funct` = `instr[2:0]`
- `RESET_PC`, 0: PC value loaded on reset

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request, held until granted
- `imem_addr`  out  AW  word address; equals `pc` while `imem_req`=1
- `imem_gnt`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  IW  response word
- `instr_valid`  out  1  instruction register holds an unretired instruction
- `instr`  out  IW  instruction register
- `op`  out  4  `instr[15:12]`, to controller
- `funct`  out  3  `instr[2:0]`, to controller
- `pc`  out  AW  address of the current instruction
- `pcplus1`  out  AW  `pc`+1 mod 2^AW
- `retire`  in  1  datapath finished the current instruction
- `pcsrc`  in  1  controller: taken branch
- `jump`  in  1  controller: jump
- `branch_target`  in  AW  branch target address
- `jump_target`  in  AW  jump target address

## Operation
- FSM states: IDLE, FETCH, WAIT, HOLD.
- **IDLE**: reset state. Unconditionally moves to FETCH on the next clock.
- **FETCH**: `imem_req`=1, `imem_addr`=`pc`.
  - `imem_gnt`=1 → WAIT.
  - Otherwise stay, with address held stable.
  - `imem_rvalid` is ignored in FETCH, so a stale response from before a reset is dropped.
- **WAIT**: `imem_req`=0. `imem_rvalid`=1 → load `instr`←`imem_rdata`, then go to HOLD.
- **HOLD**: `instr_valid`=1. `retire`=1 → update `pc`←next_pc, then go to FETCH.
- next_pc priority:
  - `jump` → `jump_target`;
  - else `pcsrc` → `branch_target`;
  - else `pcplus1`.
  - `jump` wins if both are asserted.
- `retire`, `pcsrc`, `jump` and the targets are sampled only in HOLD with `retire`=1; they are ignored in all other states.
- `pc` changes only on retire. `instr` changes only on a WAIT+rvalid capture.
- PC arithmetic is unsigned AW-bit and wraps: `pc`=2^AW-1 with no redirect → 0.
- `imem_req`, `imem_addr` and `instr_valid` are decoded from state, registered state only; there is no combinational path from inputs.
- Reset values: state=IDLE, `pc`=`RESET_PC`, `instr`=0, `imem_req`=0, `instr_valid`=0, `op`=0, `funct`=0, `pcplus1`=`RESET_PC`+1.

## Timing
- Reset is asynchronous: asserting `rst_n` low mid-fetch clears all state immediately. The first request is raised in the second cycle after `rst_n` rises (IDLE, then FETCH).
- Best case, `imem_gnt` in the first FETCH cycle and `imem_rvalid` in the first WAIT cycle:
  - `instr_valid` rises 2 cycles after `imem_req` rises;
  - one instruction per 3 cycles with back-to-back retires.
- `imem_gnt` and `imem_rvalid` for the same request never occur in the same cycle. The memory guarantees this; `imem_rvalid` in FETCH is discarded.
- Exactly one request is outstanding at a time.
- `retire` in the first HOLD cycle → FETCH on the next cycle with the new `pc` already on `imem_addr`.
- Wait states are unbounded: any number of FETCH or WAIT cycles is legal, with outputs stable throughout.

## Structure
- Shared package `core_pkg` holds:
  - state enum `fetch_state_t` (IDLE, FETCH, WAIT, HOLD);
  - `OP_MSB`/`OP_LSB`, `FUNCT_MSB`/`FUNCT_LSB` field constants, also used by the controller decode;
  - default `AW`/`IW`.
- One sub-module, `pc_next_sel`: combinational jump/branch/increment priority mux producing next_pc and `pcplus1`. The FSM, PC and instruction register live in `instr_fetch`.

## Test plan
- Reset, then zero-wait memory returning 0x1234 at address 0:
  - `imem_req` rises 2 cycles after `rst_n` release; `instr_valid`=1 two cycles later;
  - `op`=0x1, `funct`=0x4, `pc`=0.
- Retire with no redirect, repeated 4 times: `imem_addr` sequence 0,1,2,3,4, one fetch every 3 cycles.
- Retire with `pcsrc`=1, `branch_target`=0x0040, then `jump`=1 and `pcsrc`=1, `jump_target`=0x0100, `branch_target`=0x0040: next fetches at 0x0040, then 0x0100.
- `imem_gnt` withheld 5 cycles and `imem_rvalid` withheld 3 cycles: `imem_req`/`imem_addr` stable throughout, `instr_valid`=0 until capture, `instr` unchanged before capture.
- `RESET_PC`=0xFFFF with no-redirect retire: next `imem_addr`=0x0000.
- `rst_n` asserted in WAIT, then stale `imem_rvalid`=1 with 0xBEEF in the first FETCH cycle after reset: data ignored, `instr`=0, `pc`=`RESET_PC`, fetch proceeds normally.
